// File: rtl/regfile_dump_reader.sv
// ============================================================================
//  Module   : regfile_dump_reader
//  Brief    : Streams a contiguous, optionally wrapping range of register-file
//             entries, tagged with their index, over a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_dump_reader #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] first_addr,
    input  logic [ADDRESS_WIDTH-1:0] last_addr,
    input  logic                     abort,
    output logic [ADDRESS_WIDTH-1:0] rf_addr,
    input  logic [DATA_WIDTH-1:0]    rf_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [ADDRESS_WIDTH-1:0] out_index,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                   state_q,     state_d;
    logic [ADDRESS_WIDTH-1:0] cur_q,       cur_d;
    logic [ADDRESS_WIDTH-1:0] last_q,      last_d;
    logic [ADDRESS_WIDTH-1:0] out_index_q, out_index_d;
    logic [DATA_WIDTH-1:0]    out_data_q,  out_data_d;
    logic                     out_valid_q, out_valid_d;

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        last_d      = last_q;
        out_index_d = out_index_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                // abort wins over a coincident start
                if (start && !abort) begin
                    cur_d   = first_addr;
                    last_d  = last_addr;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    out_data_d  = rf_data;
                    out_index_d = cur_q;
                    out_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (cur_q == last_q) begin
                        state_d = S_DONE;
                    end else begin
                        // natural wrap of the index gives the modulo range
                        cur_d   = cur_q + ADDRESS_WIDTH'(1);
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            last_q      <= '0;
            out_index_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            last_q      <= last_d;
            out_index_q <= out_index_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign rf_addr   = cur_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign busy      = (state_q != S_IDLE);
    // an abort landing in DONE suppresses the completion pulse
    assign done      = (state_q == S_DONE) && !abort;

endmodule

`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
// ============================================================================
//  Module   : tb_regfile_dump_reader
//  Brief    : Self-checking bench for regfile_dump_reader.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_dump_reader;

    localparam int AW     = 5;
    localparam int DW     = 32;
    localparam int NREG   = 32;
    localparam int BUDGET = 1000;

    typedef struct {
        int first;
        int last;
        int mode;       // 0: ready high, 1: 4-cycle stall per word, 2: random ready
        bit poke;       // pulse a conflicting start mid-dump
        int exp_words;
        int exp_busy;   // negative: not checked
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] first_addr = '0;
    logic [AW-1:0] last_addr = '0;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_index;
    logic          busy;
    logic          done;

    logic [DW-1:0] rf_mem [NREG];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // register file model: x0 is hardwired to zero
    always_comb rf_data = (rf_addr == '0) ? '0 : rf_mem[rf_addr];

    regfile_dump_reader #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .first_addr(first_addr),
        .last_addr (last_addr),
        .abort     (abort),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got timeout required event", name);
    endtask

    function automatic logic [DW-1:0] ref_data(input int idx);
        return (idx == 0) ? '0 : rf_mem[idx];
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_rf_addr"},   rf_addr,   0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"},  out_data,  0);
        check({tag, "_out_index"}, out_index, 0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
    endtask

    task automatic start_dump(input int f, input int l);
        @(posedge clk); #1;
        start      = 1'b1;
        first_addr = f[AW-1:0];
        last_addr  = l[AW-1:0];
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_dump(input vec_t v);
        int q[$];
        int idx;
        int cyc;
        int stall;
        int words;
        int dones;
        int busy_cnt;
        bit rdy;
        // expected order: walk upward from first, wrapping, until last is emitted
        idx = v.first;
        q.push_back(idx);
        while (idx != v.last) begin
            idx = (idx + 1) % NREG;
            q.push_back(idx);
        end
        out_ready = 1'b0;
        start_dump(v.first, v.last);
        cyc = 0; stall = 0; words = 0; dones = 0; busy_cnt = 0;
        while (cyc < BUDGET) begin
            if (!busy) break;
            busy_cnt++;
            if (done) begin
                dones++;
                check("done_before_all_words", q.size(), 0);
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    timeout_fail("extra_word");
                    rdy = 1'b1;
                end else begin
                    check("out_index", out_index, q[0]);
                    check("out_data",  out_data,  ref_data(q[0]));
                    case (v.mode)
                        0:       rdy = 1'b1;
                        1:       rdy = (stall == 4);
                        default: rdy = $urandom_range(0, 1) == 1;
                    endcase
                    stall++;
                    if (rdy) begin
                        void'(q.pop_front());
                        words++;
                        stall = 0;
                    end
                end
                out_ready = rdy;
            end else begin
                if (!done && q.size() > 0)
                    check("rf_addr", rf_addr, q[0]);
                out_ready = (v.mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
            end
            if (v.poke && cyc == 2) begin
                start      = 1'b1;
                first_addr = ~v.first[AW-1:0];
                last_addr  = ~v.last[AW-1:0];
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b0;
        if (cyc >= BUDGET) timeout_fail("dump_timeout");
        check("word_count", words, v.exp_words);
        check("done_pulses", dones, 1);
        if (v.exp_busy >= 0) check("busy_cycles", busy_cnt, v.exp_busy);
    endtask

    initial begin
        vec_t tbl[6];
        vec_t rv;
        bit   found;

        tbl[0] = '{first: 0,  last: 31, mode: 0, poke: 1'b0, exp_words: 32, exp_busy: 65};
        tbl[1] = '{first: 5,  last: 7,  mode: 1, poke: 1'b0, exp_words: 3,  exp_busy: 19};
        tbl[2] = '{first: 30, last: 1,  mode: 0, poke: 1'b0, exp_words: 4,  exp_busy: 9};
        tbl[3] = '{first: 12, last: 12, mode: 0, poke: 1'b0, exp_words: 1,  exp_busy: 3};
        tbl[4] = '{first: 31, last: 0,  mode: 0, poke: 1'b1, exp_words: 2,  exp_busy: 5};
        tbl[5] = '{first: 0,  last: 0,  mode: 1, poke: 1'b1, exp_words: 1,  exp_busy: 7};

        for (int k = 0; k < NREG; k++) rf_mem[k] = 32'h100 + k;

        #1;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_dump(tbl[i]);

        // abort in HOLD of the third word; the pending handshake is discarded
        start_dump(0, 31);
        out_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (out_valid && out_index == 5'd2) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!found) timeout_fail("abort_wait");
        abort = 1'b1;
        check("abort_done_same_cycle", done, 0);
        @(posedge clk); #1;
        abort = 1'b0;
        out_ready = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", out_valid, 0);
        for (int c = 0; c < 3; c++) begin
            check("abort_no_done", done, 0);
            @(posedge clk); #1;
        end
        rv = '{first: 3, last: 3, mode: 0, poke: 1'b0, exp_words: 1, exp_busy: 3};
        run_dump(rv);

        // start and abort together in IDLE: nothing happens
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; first_addr = 5'd20; last_addr = 5'd22;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", busy, 0);
        check("start_abort_rf_addr", rf_addr, 3);
        @(posedge clk); #1;
        check("start_abort_busy2", busy, 0);

        // asynchronous reset between edges while holding a word
        start_dump(9, 12);
        out_ready = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            if (out_valid) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!found) timeout_fail("reset_wait");
        check("pre_reset_index", out_index, 9);
        #1 rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("post_reset_idle", busy, 0);
        rv = '{first: 4, last: 6, mode: 0, poke: 1'b0, exp_words: 3, exp_busy: 7};
        run_dump(rv);

        // randomized ranges, contents and backpressure
        for (int it = 0; it < 20; it++) begin
            for (int k = 0; k < NREG; k++) rf_mem[k] = $urandom;
            rv.first     = $urandom_range(0, NREG - 1);
            rv.last      = $urandom_range(0, NREG - 1);
            rv.mode      = 2;
            rv.poke      = $urandom_range(0, 1) == 1;
            rv.exp_words = ((rv.last - rv.first + NREG) % NREG) + 1;
            rv.exp_busy  = -1;
            run_dump(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
